// File: rtl/score_keeper.sv
// score_keeper: pong game control with score keeping, serve/point/over sequencing and a 7-segment scan
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 60,
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       start,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic [6:0] seg,
  output logic [3:0] an
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] POINT = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  logic [1:0]              state, nxt;
  logic [7:0]              pause_cnt;
  logic                    start_q;
  logic                    start_rise;
  logic                    won;
  logic                    pause_done;
  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic [6:0]              dig_seg;
  logic [6:0]              seg_nxt;

  assign start_rise = start & ~start_q;
  assign won        = (score1 == 4'(WIN_SCORE)) || (score2 == 4'(WIN_SCORE));
  assign pause_done = frame_tick && (pause_cnt + 8'd1 == 8'(PAUSE_FRAMES));
  assign sel        = cnt[REFRESH_BITS-1 -: 2];

  // next game state; a win takes priority over the pause timing out
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_rise ? PLAY : IDLE;
      PLAY:    nxt = (miss_left || miss_right) ? POINT : PLAY;
      POINT:   nxt = won ? OVER : pause_done ? PLAY : POINT;
      default: nxt = start_rise ? IDLE : OVER;
    endcase
  end

  // state, scores, serve direction, pause timer and the re-centre pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      score1     <= 4'd0;
      score2     <= 4'd0;
      serve_dir  <= 1'b0;
      pause_cnt  <= 8'd0;
      ball_reset <= 1'b0;
    end else begin
      state      <= nxt;
      start_q    <= start;
      ball_reset <= 1'b0;
      case (state)
        PLAY: begin
          if (miss_left) begin
            score2     <= score2 + 4'd1;
            serve_dir  <= 1'b0;
            pause_cnt  <= 8'd0;
            ball_reset <= 1'b1;
          end else if (miss_right) begin
            score1     <= score1 + 4'd1;
            serve_dir  <= 1'b1;
            pause_cnt  <= 8'd0;
            ball_reset <= 1'b1;
          end
        end
        POINT: if (!won && frame_tick) pause_cnt <= pause_cnt + 8'd1;
        OVER: begin
          if (start_rise) begin
            score1     <= 4'd0;
            score2     <= 4'd0;
            serve_dir  <= 1'b0;
            ball_reset <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // status outputs follow the state being entered so they change with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_en   <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      ball_en   <= nxt == PLAY;
      game_over <= nxt == OVER;
      winner    <= (nxt == OVER) & ~serve_dir;
    end
  end

  // digit decode, active-low {g,f,e,d,c,b,a}
  always_comb begin
    digit = (sel == 2'd0) ? score2 : score1;
    case (digit)
      4'd0:    dig_seg = 7'b1000000;
      4'd1:    dig_seg = 7'b1111001;
      4'd2:    dig_seg = 7'b0100100;
      4'd3:    dig_seg = 7'b0110000;
      4'd4:    dig_seg = 7'b0011001;
      4'd5:    dig_seg = 7'b0010010;
      4'd6:    dig_seg = 7'b0000010;
      4'd7:    dig_seg = 7'b1111000;
      4'd8:    dig_seg = 7'b0000000;
      4'd9:    dig_seg = 7'b0010000;
      default: dig_seg = 7'h7F;
    endcase
    seg_nxt = (sel == 2'd1) ? 7'h7F :
              (sel == 2'd2) ? (game_over ? 7'b0111111 : 7'h7F) : dig_seg;
  end

  // free-running scan; anode and segments register together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      cnt <= cnt + 1'b1;
      an  <= ~(4'b0001 << sel);
      seg <= seg_nxt;
    end
  end
endmodule
